// File: rtl/max7219_pkg.sv
// Shared types, constants and helpers for the MAX7219 driver blocks.
package max7219_pkg;

  localparam int unsigned C_MAX7219_FRAME_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANTED,
    S_RELEASE
  } t_arb_state;

  // Up to 8 requesters; callers zero-extend narrower vectors.
  function automatic logic [2:0] f_onehot2idx(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (onehot[i]) idx |= 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/max7219_if_arbiter_if.sv
// Requester-side and serializer-side signals of the shared max7219_if arbiter.
interface max7219_if_arbiter_if #(
  parameter int unsigned G_NB_REQ     = 3,
  parameter int unsigned G_DATA_WIDTH = 16
);
  logic [G_NB_REQ-1:0]              i_req;
  logic [G_NB_REQ-1:0]              i_start;
  logic [G_NB_REQ-1:0]              i_en_load;
  logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_data;
  logic [G_NB_REQ-1:0]              o_gnt;
  logic [G_NB_REQ-1:0]              o_done;
  logic                             o_max7219_if_start;
  logic                             o_max7219_if_en_load;
  logic [G_DATA_WIDTH-1:0]          o_max7219_if_data;
  logic                             i_max7219_if_done;
  logic                             o_busy;
  logic                             o_protocol_err;

  modport slave (
    input  i_req, i_start, i_en_load, i_data, i_max7219_if_done,
    output o_gnt, o_done, o_max7219_if_start, o_max7219_if_en_load, o_max7219_if_data,
    output o_busy, o_protocol_err
  );

  modport master (
    output i_req, i_start, i_en_load, i_data, i_max7219_if_done,
    input  o_gnt, o_done, o_max7219_if_start, o_max7219_if_en_load, o_max7219_if_data,
    input  o_busy, o_protocol_err
  );
endinterface

// File: rtl/max7219_rr_pick.sv
// Combinational round-robin picker: first set request after rr_ptr_i, with wrap.
module max7219_rr_pick
  import max7219_pkg::*;
#(
  parameter int unsigned G_NB_REQ = 3,
  localparam int unsigned IdxW    = (G_NB_REQ > 1) ? $clog2(G_NB_REQ) : 1
) (
  input  logic [G_NB_REQ-1:0] req_i,
  input  logic [IdxW-1:0]     rr_ptr_i,
  output logic [G_NB_REQ-1:0] onehot_o,
  output logic [IdxW-1:0]     idx_o
);

  logic [IdxW-1:0] k;
  logic            found;

  always_comb begin
    onehot_o = '0;
    found    = 1'b0;
    k        = '0;
    for (int unsigned i = 1; i <= G_NB_REQ; i++) begin
      k = IdxW'((rr_ptr_i + i) % G_NB_REQ);
      if (!found && req_i[k]) begin
        onehot_o[k] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign idx_o = IdxW'(f_onehot2idx(8'(onehot_o)));

endmodule

// File: rtl/max7219_if_arbiter.sv
// Round-robin owner arbiter in front of a single max7219_if serializer; never switches owner
// while a frame is in flight and routes done back to the owner only.
module max7219_if_arbiter
  import max7219_pkg::*;
#(
  parameter int unsigned G_NB_REQ     = 3,
  parameter int unsigned G_DATA_WIDTH = C_MAX7219_FRAME_WIDTH
) (
  input logic               clk,
  input logic               rst,
  max7219_if_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (G_NB_REQ > 1) ? $clog2(G_NB_REQ) : 1;

  t_arb_state              state_q, state_d;
  logic                    pending_q, pending_d;
  logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]         owner_q, owner_d;
  logic [G_NB_REQ-1:0]     gnt_q, gnt_d;
  logic [G_NB_REQ-1:0]     done_q, done_d;
  logic                    start_q, start_d;
  logic                    en_load_q, en_load_d;
  logic [G_DATA_WIDTH-1:0] data_q, data_d;
  logic                    err_q, err_d;
  logic [G_NB_REQ-1:0]     pick_onehot;
  logic [IdxW-1:0]         pick_idx;

  max7219_rr_pick #(
    .G_NB_REQ(G_NB_REQ)
  ) u_pick (
    .req_i   (bus.i_req),
    .rr_ptr_i(rr_ptr_q),
    .onehot_o(pick_onehot),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    start_d   = 1'b0;
    en_load_d = en_load_q;
    data_d    = data_q;
    err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.i_req) begin
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
          state_d = S_GRANTED;
        end
      end
      S_GRANTED: begin
        // Done retires the frame before this cycle's start is judged.
        if (bus.i_max7219_if_done && pending_q) begin
          pending_d       = 1'b0;
          done_d[owner_q] = 1'b1;
        end
        if (bus.i_start[owner_q]) begin
          if (!pending_d) begin
            start_d   = 1'b1;
            data_d    = bus.i_data[owner_q*G_DATA_WIDTH +: G_DATA_WIDTH];
            en_load_d = bus.i_en_load[owner_q];
            pending_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (!bus.i_req[owner_q]) begin
          if (pending_d) begin
            state_d = S_RELEASE;
          end else begin
            state_d  = S_IDLE;
            gnt_d    = '0;
            rr_ptr_d = owner_q;
          end
        end
      end
      S_RELEASE: begin
        if (bus.i_max7219_if_done) begin
          done_d[owner_q] = 1'b1;
          pending_d       = 1'b0;
          rr_ptr_d        = owner_q;
          gnt_d           = '0;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      rr_ptr_q  <= IdxW'(G_NB_REQ - 1);
      owner_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      start_q   <= 1'b0;
      en_load_q <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      start_q   <= start_d;
      en_load_q <= en_load_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_gnt                = gnt_q;
  assign bus.o_done               = done_q;
  assign bus.o_max7219_if_start   = start_q;
  assign bus.o_max7219_if_en_load = en_load_q;
  assign bus.o_max7219_if_data    = data_q;
  assign bus.o_busy               = (state_q != S_IDLE);
  assign bus.o_protocol_err       = err_q;

endmodule

// File: tb/tb_max7219_if_arbiter.sv
// Directed self-checking bench for max7219_if_arbiter (3 requesters, 16-bit frames).
module tb_max7219_if_arbiter;

  localparam int unsigned NB = 3;
  localparam int unsigned W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  max7219_if_arbiter_if #(.G_NB_REQ(NB), .G_DATA_WIDTH(W)) bus ();

  max7219_if_arbiter #(
    .G_NB_REQ    (NB),
    .G_DATA_WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req             = '0;
    bus.i_start           = '0;
    bus.i_en_load         = '0;
    bus.i_data            = '0;
    bus.i_max7219_if_done = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({bus.o_gnt, bus.o_done, bus.o_max7219_if_start, bus.o_max7219_if_en_load,
         bus.o_max7219_if_data, bus.o_busy, bus.o_protocol_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%b done=%b start=%b data=%h busy=%b err=%b, want all 0",
               bus.o_gnt, bus.o_done, bus.o_max7219_if_start, bus.o_max7219_if_data,
               bus.o_busy, bus.o_protocol_err);
    end
    rst = 1'b0;
    step();
    total++;
    if (bus.o_gnt !== 3'b000 || bus.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: gnt=%b busy=%b want 000/0", bus.o_gnt, bus.o_busy);
    end
  endtask

  task automatic test_single();
    bus.i_req = 3'b001;
    step();
    total++;
    if (bus.o_gnt !== 3'b001 || bus.o_busy !== 1'b1) begin
      bad++;
      $display("FAIL single_gnt: gnt=%b busy=%b want 001/1", bus.o_gnt, bus.o_busy);
    end
    bus.i_start     = 3'b001;
    bus.i_en_load   = 3'b001;
    bus.i_data[15:0] = 16'h0C01;
    step();
    bus.i_start = 3'b000;
    total++;
    if (bus.o_max7219_if_start !== 1'b1 || bus.o_max7219_if_data !== 16'h0C01 ||
        bus.o_max7219_if_en_load !== 1'b1) begin
      bad++;
      $display("FAIL single_start: start=%b data=%h en=%b want 1/0c01/1",
               bus.o_max7219_if_start, bus.o_max7219_if_data, bus.o_max7219_if_en_load);
    end
    step();
    total++;
    if (bus.o_max7219_if_start !== 1'b0 || bus.o_max7219_if_data !== 16'h0C01) begin
      bad++;
      $display("FAIL single_hold: start=%b data=%h want 0/0c01",
               bus.o_max7219_if_start, bus.o_max7219_if_data);
    end
    bus.i_max7219_if_done = 1'b1;
    step();
    bus.i_max7219_if_done = 1'b0;
    total++;
    if (bus.o_done !== 3'b001) begin
      bad++;
      $display("FAIL single_done: done=%b want 001", bus.o_done);
    end
    step();
    total++;
    if (bus.o_done !== 3'b000) begin
      bad++;
      $display("FAIL single_done_pulse: done=%b want 000", bus.o_done);
    end
    bus.i_req = 3'b000;
    step();
    total++;
    if (bus.o_gnt !== 3'b000 || bus.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL single_release: gnt=%b busy=%b want 000/0", bus.o_gnt, bus.o_busy);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_oh;
    logic [2:0]  nxt_oh;
    logic [15:0] word;
    do_reset();
    bus.i_req = 3'b111;
    step();
    for (int i = 0; i < 4; i++) begin
      exp_oh = 3'(1 << (i % 3));
      nxt_oh = 3'(1 << ((i + 1) % 3));
      word   = 16'hA000 + 16'(i);
      total++;
      if (bus.o_gnt !== exp_oh) begin
        bad++;
        $display("FAIL rr_gnt[%0d]: gnt=%b want %b", i, bus.o_gnt, exp_oh);
      end
      bus.i_start                 = exp_oh;
      bus.i_data[(i % 3)*W +: W] = word;
      step();
      bus.i_start = 3'b000;
      total++;
      if (bus.o_max7219_if_start !== 1'b1 || bus.o_max7219_if_data !== word) begin
        bad++;
        $display("FAIL rr_frame[%0d]: start=%b data=%h want 1/%h",
                 i, bus.o_max7219_if_start, bus.o_max7219_if_data, word);
      end
      bus.i_max7219_if_done = 1'b1;
      step();
      bus.i_max7219_if_done = 1'b0;
      total++;
      if (bus.o_done !== exp_oh) begin
        bad++;
        $display("FAIL rr_done[%0d]: done=%b want %b", i, bus.o_done, exp_oh);
      end
      bus.i_req = bus.i_req & ~exp_oh;
      step();
      total++;
      if (bus.o_gnt !== 3'b000 || bus.o_busy !== 1'b0) begin
        bad++;
        $display("FAIL rr_idle[%0d]: gnt=%b busy=%b want 000/0", i, bus.o_gnt, bus.o_busy);
      end
      bus.i_req = 3'b111;
      step();
      if (i < 3) begin
        total++;
        if (bus.o_gnt !== nxt_oh) begin
          bad++;
          $display("FAIL rr_turnaround[%0d]: gnt=%b want %b", i, bus.o_gnt, nxt_oh);
        end
      end
    end
    bus.i_req = 3'b000;
  endtask

  task automatic test_release();
    do_reset();
    bus.i_req = 3'b010;
    step();
    total++;
    if (bus.o_gnt !== 3'b010) begin
      bad++;
      $display("FAIL rel_gnt: gnt=%b want 010", bus.o_gnt);
    end
    bus.i_start       = 3'b010;
    bus.i_data[31:16] = 16'h1234;
    step();
    bus.i_start = 3'b000;
    total++;
    if (bus.o_max7219_if_start !== 1'b1 || bus.o_max7219_if_data !== 16'h1234) begin
      bad++;
      $display("FAIL rel_frame: start=%b data=%h want 1/1234",
               bus.o_max7219_if_start, bus.o_max7219_if_data);
    end
    bus.i_req = 3'b000;
    step();
    total++;
    if (bus.o_gnt !== 3'b010 || bus.o_busy !== 1'b1) begin
      bad++;
      $display("FAIL rel_hold: gnt=%b busy=%b want 010/1", bus.o_gnt, bus.o_busy);
    end
    bus.i_start       = 3'b010;
    bus.i_data[31:16] = 16'h5678;
    step();
    bus.i_start = 3'b000;
    total++;
    if (bus.o_max7219_if_start !== 1'b0 || bus.o_protocol_err !== 1'b0 ||
        bus.o_max7219_if_data !== 16'h1234 || bus.o_gnt !== 3'b010) begin
      bad++;
      $display("FAIL rel_start_ignored: start=%b err=%b data=%h gnt=%b want 0/0/1234/010",
               bus.o_max7219_if_start, bus.o_protocol_err, bus.o_max7219_if_data, bus.o_gnt);
    end
    bus.i_max7219_if_done = 1'b1;
    step();
    bus.i_max7219_if_done = 1'b0;
    total++;
    if (bus.o_done !== 3'b010 || bus.o_gnt !== 3'b000) begin
      bad++;
      $display("FAIL rel_done: done=%b gnt=%b want 010/000", bus.o_done, bus.o_gnt);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    bus.i_req = 3'b001;
    step();
    bus.i_start      = 3'b001;
    bus.i_data[15:0] = 16'h0A55;
    step();
    total++;
    if (bus.o_max7219_if_start !== 1'b1 || bus.o_protocol_err !== 1'b0) begin
      bad++;
      $display("FAIL ovr_first: start=%b err=%b want 1/0",
               bus.o_max7219_if_start, bus.o_protocol_err);
    end
    bus.i_data[15:0] = 16'h0BEE;
    step();
    bus.i_start = 3'b000;
    total++;
    if (bus.o_max7219_if_start !== 1'b0 || bus.o_protocol_err !== 1'b1 ||
        bus.o_max7219_if_data !== 16'h0A55) begin
      bad++;
      $display("FAIL ovr_reject: start=%b err=%b data=%h want 0/1/0a55",
               bus.o_max7219_if_start, bus.o_protocol_err, bus.o_max7219_if_data);
    end
    step();
    total++;
    if (bus.o_protocol_err !== 1'b0) begin
      bad++;
      $display("FAIL ovr_err_pulse: err=%b want 0", bus.o_protocol_err);
    end
    bus.i_max7219_if_done = 1'b1;
    step();
    bus.i_max7219_if_done = 1'b0;
    total++;
    if (bus.o_done !== 3'b001) begin
      bad++;
      $display("FAIL ovr_done: done=%b want 001", bus.o_done);
    end
  endtask

  task automatic test_simultaneous();
    // Requester 0 still owns the serializer with nothing pending.
    bus.i_start       = 3'b100;
    bus.i_data[47:32] = 16'hDEAD;
    step();
    bus.i_start = 3'b000;
    total++;
    if (bus.o_max7219_if_start !== 1'b0 || bus.o_protocol_err !== 1'b0) begin
      bad++;
      $display("FAIL nonowner_start: start=%b err=%b want 0/0",
               bus.o_max7219_if_start, bus.o_protocol_err);
    end
    bus.i_start      = 3'b001;
    bus.i_data[15:0] = 16'h0F00;
    step();
    bus.i_start = 3'b000;
    step();
    bus.i_start           = 3'b001;
    bus.i_data[15:0]      = 16'h0F01;
    bus.i_max7219_if_done = 1'b1;
    step();
    bus.i_start           = 3'b000;
    bus.i_max7219_if_done = 1'b0;
    total++;
    if (bus.o_done !== 3'b001 || bus.o_max7219_if_start !== 1'b1 ||
        bus.o_max7219_if_data !== 16'h0F01 || bus.o_protocol_err !== 1'b0) begin
      bad++;
      $display("FAIL done_and_start: done=%b start=%b data=%h err=%b want 001/1/0f01/0",
               bus.o_done, bus.o_max7219_if_start, bus.o_max7219_if_data, bus.o_protocol_err);
    end
    bus.i_start = 3'b001;
    step();
    bus.i_start = 3'b000;
    total++;
    if (bus.o_protocol_err !== 1'b1 || bus.o_max7219_if_start !== 1'b0) begin
      bad++;
      $display("FAIL still_pending: err=%b start=%b want 1/0",
               bus.o_protocol_err, bus.o_max7219_if_start);
    end
    bus.i_max7219_if_done = 1'b1;
    step();
    total++;
    if (bus.o_done !== 3'b001) begin
      bad++;
      $display("FAIL pending_done: done=%b want 001", bus.o_done);
    end
    step();
    bus.i_max7219_if_done = 1'b0;
    total++;
    if (bus.o_done !== 3'b000) begin
      bad++;
      $display("FAIL spurious_done: done=%b want 000", bus.o_done);
    end
  endtask

  task automatic test_reset_mid();
    bus.i_start      = 3'b001;
    bus.i_en_load    = 3'b001;
    bus.i_data[15:0] = 16'h0777;
    step();
    bus.i_start = 3'b000;
    rst = 1'b1;
    #1;
    total++;
    if (bus.o_gnt !== 3'b000 || bus.o_busy !== 1'b0 || bus.o_max7219_if_data !== 16'h0000 ||
        bus.o_max7219_if_start !== 1'b0 || bus.o_max7219_if_en_load !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: gnt=%b busy=%b data=%h start=%b en=%b want all 0",
               bus.o_gnt, bus.o_busy, bus.o_max7219_if_data, bus.o_max7219_if_start,
               bus.o_max7219_if_en_load);
    end
    step();
    rst       = 1'b0;
    bus.i_req = 3'b110;
    step();
    total++;
    if (bus.o_gnt !== 3'b010) begin
      bad++;
      $display("FAIL reset_first_gnt: gnt=%b want 010", bus.o_gnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_release();
    test_overrun();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
